// File: rtl/seg_data_formatter.sv
// 32-bit value to eight active-low 7-segment digit patterns, hex or unsigned decimal.
// Decimal uses a sequential double-dabble (one bit per cycle) ahead of the encode step.
module seg_data_formatter #(
    parameter bit         LZ_BLANK = 1'b1,
    parameter logic [7:0] DP_MASK  = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        mode,
    input  logic [31:0] value,
    output logic [31:0] display2,
    output logic [31:0] display1,
    output logic        busy,
    output logic        done,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

    state_t      r_state;
    logic [31:0] r_val;
    logic        r_mode;
    logic [39:0] r_bcd;
    logic [4:0]  r_cnt;
    logic [31:0] r_disp2, r_disp1;
    logic        r_busy, r_done, r_ovf;

    logic [39:0]      w_adj;
    logic [7:0][3:0]  w_dig;
    logic [7:0][7:0]  w_seg;
    logic             w_ovf;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;  4'h2: seg7 = 8'h25;  4'h3: seg7 = 8'h0D;
            4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;  4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;
            4'h8: seg7 = 8'h01;  4'h9: seg7 = 8'h09;  4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
            4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;  4'hE: seg7 = 8'h61;  default: seg7 = 8'h71;
        endcase
    endfunction

    // Add-3 correction on every BCD nibble before the shift
    always_comb begin
        w_adj = '0;
        for (int i = 0; i < 10; i++)
            w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
    end

    assign w_ovf = r_mode & (|r_bcd[39:32]);

    always_comb begin
        logic lead;
        lead  = 1'b1;
        w_dig = '0;
        w_seg = '0;
        for (int i = 7; i >= 0; i--) begin
            w_dig[i] = r_mode ? r_bcd[4*i +: 4] : r_val[4*i +: 4];
            w_seg[i] = seg7(w_dig[i]);
            // Walking down from digit 7, blank until the first nonzero digit
            if (LZ_BLANK && !w_ovf && i != 0 && lead && w_dig[i] == 4'd0)
                w_seg[i] = 8'hFF;
            else
                lead = 1'b0;
            if (DP_MASK[i])
                w_seg[i][0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_val   <= '0;
            r_mode  <= 1'b0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp2 <= 32'hFFFF_FFFF;
            r_disp1 <= 32'hFFFF_FFFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy stays up for the done cycle, so a load there is still ignored
                    if (load && !r_busy) begin
                        r_val   <= value;
                        r_mode  <= mode;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= mode ? CONV : ENC;
                    end else if (r_done) begin
                        r_busy <= 1'b0;
                    end
                end
                CONV: begin
                    r_bcd <= {w_adj[38:0], r_val[31]};
                    r_val <= {r_val[30:0], 1'b0};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= ENC;
                end
                ENC: begin
                    r_disp2 <= w_seg[7:4];
                    r_disp1 <= w_seg[3:0];
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign display2 = r_disp2;
    assign display1 = r_disp1;
    assign busy     = r_busy;
    assign done     = r_done;
    assign ovf      = r_ovf;
endmodule

// File: tb/tb_seg_data_formatter.sv
// Scoreboard bench for seg_data_formatter: stimulus pushes model results, a monitor
// pops and compares whenever done pulses.
module tb_seg_data_formatter;
    localparam bit         LZ = 1'b1;
    localparam logic [7:0] DP = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] value = '0;
    logic [31:0] display2, display1;
    logic        busy, done, ovf;

    typedef struct {
        logic [31:0] d2;
        logic [31:0] d1;
        logic        ov;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic [7:0] SEG [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    seg_data_formatter #(.LZ_BLANK(LZ), .DP_MASK(DP)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .mode(mode), .value(value),
        .display2(display2), .display1(display1), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: digits by repeated division, blank above the top nonzero digit
    function automatic void model(input bit m, input logic [31:0] v,
                                  output logic [31:0] d2, output logic [31:0] d1, output logic ov);
        int unsigned x, dg[8];
        int top;
        logic [7:0] s;
        x  = v;
        ov = m && (v >= 32'd100_000_000);
        for (int i = 0; i < 8; i++) begin
            dg[i] = m ? x % 10 : x % 16;
            x     = m ? x / 10 : x / 16;
        end
        top = 0;
        for (int i = 0; i < 8; i++) if (dg[i] != 0) top = i;
        d1 = '0; d2 = '0;
        for (int i = 0; i < 8; i++) begin
            s = SEG[dg[i]];
            if (LZ && !ov && i > top) s = 8'hFF;
            if (DP[i]) s[0] = 1'b0;
            if (i < 4) d1[8*i +: 8] = s;
            else       d2[8*(i-4) +: 8] = s;
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: done=1 with no pending conversion (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("display2", display2, e.d2);
                check("display1", display1, e.d1);
                check("ovf", {31'd0, ovf}, {31'd0, e.ov});
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic conv(input bit m, input logic [31:0] v, input bit interfere);
        exp_t e;
        int   n0;
        bit   seen;
        @(negedge clk);
        load = 1'b1; mode = m; value = v;
        model(m, v, e.d2, e.d1, e.ov);
        e.cyc = cyc + (m ? 34 : 2);
        sb.push_back(e);
        n0 = done_cnt;
        @(negedge clk);
        load = 1'b0; mode = ~m; value = $urandom;
        #1 check("busy_rise", {31'd0, busy}, 32'd1);
        seen = 1'b0;
        for (int k = 2; k <= 60; k++) begin
            @(negedge clk);
            load = interfere && (k == 5 || k == 33);
            if (load) begin mode = $urandom_range(0, 1); value = $urandom; end
            #1;
            if (done_cnt != n0) begin seen = 1'b1; break; end
        end
        load = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL timeout: no done within 60 cycles (mode %0d value %h)", m, v);
            sb.delete();
        end
        @(negedge clk);
        #1;
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("done_count", done_cnt, n0 + 1);
    endtask

    initial begin
        logic [31:0] v;
        repeat (3) @(negedge clk);
        #1;
        check("rst_display2", display2, 32'hFFFF_FFFF);
        check("rst_display1", display1, 32'hFFFF_FFFF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        conv(1'b0, 32'h0000_00A5, 1'b0);
        check("hexA5_d2", display2, 32'hFFFF_FFFF);
        check("hexA5_d1", display1, 32'hFFFF_1149);
        conv(1'b1, 32'd12345678, 1'b0);
        check("dec_d2", display2, 32'h9F25_0D99);
        check("dec_d1", display1, 32'h4941_1F01);
        conv(1'b1, 32'd0, 1'b0);
        check("dec0_d1", display1, 32'hFFFF_FF03);
        conv(1'b1, 32'd100_000_000, 1'b0);
        check("ovf_d2", display2, 32'h0303_0303);
        check("ovf_flag", {31'd0, ovf}, 32'd1);
        conv(1'b1, 32'd87654321, 1'b1);

        // Reset in the middle of a decimal conversion
        @(negedge clk);
        load = 1'b1; mode = 1'b1; value = 32'd99999999;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_display2", display2, 32'hFFFF_FFFF);
        check("midrst_display1", display1, 32'hFFFF_FFFF);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        conv(1'b0, 32'hFFFF_FFFF, 1'b0);
        check("hexF_d2", display2, 32'h7171_7171);
        check("hexF_d1", display1, 32'h7171_7171);

        for (int i = 0; i < 40; i++) begin
            case (i % 4)
                0: v = $urandom_range(0, 999);
                1: v = $urandom_range(99_999_990, 100_000_010);
                2: v = $urandom & 32'h000F_FFFF;
                default: v = $urandom;
            endcase
            conv($urandom_range(0, 1), v, (i % 7) == 3);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
